// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one UART frame transmitter
// among N_REQ byte requesters. The winning byte and the frame configuration are
// latched at grant time and held steady for the transmitter until the next grant.
module uart_tx_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               baud_clk,
  input  logic               arst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               cfg_data_length,
  input  logic               cfg_stop_bits,
  input  logic [1:0]         cfg_parity_type,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               timeout_err,
  output logic               send,
  output logic [7:0]         data_in,
  output logic               data_length,
  output logic               stop_bits,
  output logic [1:0]         parity_type,
  output logic               parity_in,
  input  logic               tx_active,
  input  logic               tx_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Parity over bits [6:0], plus bit 7 for 8-bit frames; odd type inverts.
  function automatic logic calc_parity(input logic [7:0] byte_v,
                                       input logic       len_8,
                                       input logic [1:0] ptype);
    logic x;
    x = (^byte_v[6:0]) ^ (byte_v[7] & len_8);
    if (ptype == 2'b01) begin
      calc_parity = ~x;
    end else begin
      calc_parity = x;
    end
  endfunction

  state_t          state_r;
  logic [IW-1:0]   last_r;
  logic [CW-1:0]   cnt_r;
  logic            send_r;
  logic            busy_r;
  logic [7:0]      data_r;
  logic            len_r;
  logic            stop_r;
  logic [1:0]      ptype_r;
  logic            par_r;

  logic            win_found_s;
  logic [IW-1:0]   win_idx_s;
  logic [IW-1:0]   scan_s;
  logic [N_REQ-1:0] gnt_s;
  logic [CW-1:0]   cnt_s;
  logic            timeout_s;
  logic [7:0]      win_byte_s;
  logic            unused_tx_done_s;

  // tx_done carries no information this scheduler needs; tx_active alone paces it.
  assign unused_tx_done_s = tx_done;

  // Round-robin search: walk from last_r+1 (wrapping) and take the first pending request.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    scan_s      = last_r;
    for (int k = 0; k < N_REQ; k++) begin
      if (scan_s == IW'(N_REQ - 1)) begin
        scan_s = {IW{1'b0}};
      end else begin
        scan_s = scan_s + IW'(1);
      end
      if (!win_found_s && req[scan_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_byte_s = req_data[{win_idx_s, 3'b000} +: 8];

  // Grant pulse is visible in the IDLE cycle itself so the requester can drop req next cycle.
  always_comb begin
    if (arst_n && (state_r == ST_IDLE) && win_found_s) begin
      gnt_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    end else begin
      gnt_s = {N_REQ{1'b0}};
    end
  end

  // cnt_s is the number of SEND cycles including the current one.
  assign cnt_s = cnt_r + CW'(1);

  // Timeout fires on the TIMEOUT-th SEND cycle unless the transmitter starts in that cycle.
  always_comb begin
    if ((state_r == ST_SEND) && !tx_active && (cnt_s == CW'(TIMEOUT))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Scheduler FSM: grant and latch in IDLE, hold send until the transmitter starts, wait for frame end.
  always_ff @(posedge baud_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= ST_IDLE;
      last_r  <= IW'(N_REQ - 1);
      cnt_r   <= {CW{1'b0}};
      send_r  <= 1'b0;
      busy_r  <= 1'b0;
      data_r  <= 8'h00;
      len_r   <= 1'b1;
      stop_r  <= 1'b0;
      ptype_r <= 2'b00;
      par_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            state_r <= ST_SEND;
            last_r  <= win_idx_s;
            cnt_r   <= {CW{1'b0}};
            send_r  <= 1'b1;
            busy_r  <= 1'b1;
            data_r  <= win_byte_s;
            len_r   <= cfg_data_length;
            stop_r  <= cfg_stop_bits;
            ptype_r <= cfg_parity_type;
            par_r   <= calc_parity(win_byte_s, cfg_data_length, cfg_parity_type);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (tx_active) begin
            state_r <= ST_ACTIVE;
            send_r  <= 1'b0;
          end else if (timeout_s) begin
            state_r <= ST_IDLE;
            send_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_s;
          end
        end
        ST_ACTIVE: begin
          if (!tx_active) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_ACTIVE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          send_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_s;
  assign busy        = busy_r;
  assign timeout_err = timeout_s;
  assign send        = send_r;
  assign data_in     = data_r;
  assign data_length = len_r;
  assign stop_bits   = stop_r;
  assign parity_type = ptype_r;
  assign parity_in   = par_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a transaction-level model predicts every
// output each cycle, and directed scenarios pin literal expectations.
module tb_uart_tx_sched;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 15;
  localparam int PH_IDLE   = 0;
  localparam int PH_SEND   = 1;
  localparam int PH_ACTIVE = 2;

  logic               baud_clk = 1'b0;
  logic               arst_n   = 1'b0;
  logic [N_REQ-1:0]   req      = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic               cfg_data_length = 1'b1;
  logic               cfg_stop_bits   = 1'b0;
  logic [1:0]         cfg_parity_type = 2'b00;
  logic [N_REQ-1:0]   gnt;
  logic               busy, timeout_err, send;
  logic [7:0]         data_in;
  logic               data_length, stop_bits, parity_in;
  logic [1:0]         parity_type;
  logic               tx_active = 1'b0;
  logic               tx_done;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int gnt_log[$];

  // model state
  int         m_phase  = PH_IDLE;
  int         m_last   = N_REQ - 1;
  int         m_sendno = 0;
  logic [7:0] m_data   = 8'h00;
  logic       m_len    = 1'b1;
  logic       m_stop   = 1'b0;
  logic [1:0] m_pt     = 2'b00;
  logic       m_par    = 1'b0;

  assign tx_done = ~tx_active;

  uart_tx_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .baud_clk(baud_clk), .arst_n(arst_n), .req(req), .req_data(req_data),
    .cfg_data_length(cfg_data_length), .cfg_stop_bits(cfg_stop_bits),
    .cfg_parity_type(cfg_parity_type), .gnt(gnt), .busy(busy),
    .timeout_err(timeout_err), .send(send), .data_in(data_in),
    .data_length(data_length), .stop_bits(stop_bits), .parity_type(parity_type),
    .parity_in(parity_in), .tx_active(tx_active), .tx_done(tx_done)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [N_REQ-1:0] r, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic model_parity(input logic [7:0] b, input logic len, input logic [1:0] pt);
    int ones;
    ones = $countones(len ? b : (b & 8'h7F));
    return (pt == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  // Model: advance the transaction-level view at each edge.
  always @(posedge baud_clk or negedge arst_n) begin
    if (!arst_n) begin
      m_phase <= PH_IDLE; m_last <= N_REQ - 1; m_sendno <= 0;
      m_data <= 8'h00; m_len <= 1'b1; m_stop <= 1'b0; m_pt <= 2'b00; m_par <= 1'b0;
    end else if (m_phase == PH_IDLE && req != '0) begin
      m_last   <= winner(req, m_last);
      m_data   <= req_data[8*winner(req, m_last) +: 8];
      m_len    <= cfg_data_length;
      m_stop   <= cfg_stop_bits;
      m_pt     <= cfg_parity_type;
      m_par    <= model_parity(req_data[8*winner(req, m_last) +: 8], cfg_data_length, cfg_parity_type);
      m_phase  <= PH_SEND;
      m_sendno <= 1;
    end else if (m_phase == PH_SEND) begin
      if (tx_active) m_phase <= PH_ACTIVE;
      else if (m_sendno == TIMEOUT) m_phase <= PH_IDLE;
      else m_sendno <= m_sendno + 1;
    end else if (m_phase == PH_ACTIVE && !tx_active) begin
      m_phase <= PH_IDLE;
    end
  end

  // Compare: every cycle, check all outputs against the model on the falling edge.
  always @(negedge baud_clk) begin
    if (chk_en) begin
      logic [N_REQ-1:0] e_gnt;
      e_gnt = '0;
      if (arst_n && m_phase == PH_IDLE && req != '0) e_gnt[winner(req, m_last)] = 1'b1;
      check("cyc_gnt", gnt, e_gnt);
      check("cyc_busy", busy, arst_n && m_phase != PH_IDLE);
      check("cyc_send", send, arst_n && m_phase == PH_SEND);
      check("cyc_timeout", timeout_err,
            arst_n && m_phase == PH_SEND && !tx_active && m_sendno == TIMEOUT);
      check("cyc_data", data_in, m_data);
      check("cyc_len", data_length, m_len);
      check("cyc_stop", stop_bits, m_stop);
      check("cyc_ptype", parity_type, m_pt);
      check("cyc_par", parity_in, m_par);
      for (int b = 0; b < N_REQ; b++) if (gnt[b]) gnt_log.push_back(b);
    end
  end

  task automatic step();
    @(posedge baud_clk);
    #2;
  endtask

  // Request one requester alone from IDLE; returns in the first SEND cycle.
  task automatic grant_one(input int idx, input logic [7:0] b, input logic len,
                           input logic stp, input logic [1:0] pt);
    logic [N_REQ-1:0] exp_g;
    req_data[8*idx +: 8] = b;
    cfg_data_length = len;
    cfg_stop_bits   = stp;
    cfg_parity_type = pt;
    req = '0;
    req[idx] = 1'b1;
    exp_g = '0;
    exp_g[idx] = 1'b1;
    #1;
    check("grant_onehot", gnt, exp_g);
    step();
    req[idx] = 1'b0;
    #1;
  endtask

  // Transmitter stand-in: once send is seen, start after dly cycles and frame for len cycles.
  task automatic serve(input int dly, input int len);
    int k;
    k = 0;
    while (send !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    check("send_seen", send, 1'b1);
    repeat (dly) step();
    tx_active = 1'b1;
    repeat (len) step();
    tx_active = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    step();
    chk_en = 1'b1;
    // reset state
    check("rst_busy", busy, 1'b0);
    check("rst_send", send, 1'b0);
    check("rst_data", data_in, 8'h00);
    check("rst_len", data_length, 1'b1);
    check("rst_gnt", gnt, 4'b0000);
    step();
    arst_n = 1'b1;

    // single request, 8-bit even parity on 0x41
    grant_one(0, 8'h41, 1'b1, 1'b0, 2'b10);
    check("t1_data", data_in, 8'h41);
    check("t1_par", parity_in, 1'b0);
    check("t1_send", send, 1'b1);
    serve(2, 4);
    check("t1_busy_after", busy, 1'b0);

    // round-robin with all four requesting, from the reset pointer
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    gnt_log.delete();
    req_data = 32'h44332211;
    req = 4'b1111;
    for (int f = 0; f < 8; f++) serve(1, 3);
    req = 4'b0000;
    check("rr_count", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) check("rr_order", gnt_log[i], i % 4);

    // parity corner cases on 0xC3
    grant_one(2, 8'hC3, 1'b0, 1'b0, 2'b01);
    check("par_7odd", parity_in, 1'b0);
    check("par_7odd_len", data_length, 1'b0);
    serve(1, 2);
    grant_one(2, 8'hC3, 1'b1, 1'b0, 2'b10);
    check("par_8even", parity_in, 1'b0);
    serve(1, 2);
    grant_one(2, 8'hC3, 1'b1, 1'b0, 2'b01);
    check("par_8odd", parity_in, 1'b1);
    serve(1, 2);

    // timeout with a second request waiting
    grant_one(1, 8'h55, 1'b1, 1'b0, 2'b10);
    req_data[31:24] = 8'h77;
    req[3] = 1'b1;
    k = 0;
    while (send === 1'b1 && k < 40) begin
      k++;
      check("to_pulse", timeout_err, (k == TIMEOUT));
      check("to_wait_gnt", gnt, 4'b0000);
      step();
      #1;
    end
    check("to_send_cycles", k, TIMEOUT);
    check("to_next_gnt", gnt, 4'b1000);
    step();
    req[3] = 1'b0;
    #1;
    check("to_next_data", data_in, 8'h77);
    serve(1, 2);

    // tx_active in the timeout cycle wins
    grant_one(0, 8'h12, 1'b1, 1'b0, 2'b00);
    repeat (TIMEOUT - 1) step();
    tx_active = 1'b1;
    #1;
    check("tie_no_err", timeout_err, 1'b0);
    check("tie_send", send, 1'b1);
    step();
    #1;
    check("tie_active_send", send, 1'b0);
    check("tie_active_busy", busy, 1'b1);
    tx_active = 1'b0;
    step();

    // config changes mid-frame are ignored until the next grant
    grant_one(0, 8'h5A, 1'b1, 1'b1, 2'b10);
    step();
    tx_active = 1'b1;
    step();
    cfg_data_length = 1'b0;
    cfg_parity_type = 2'b01;
    cfg_stop_bits   = 1'b0;
    req_data[7:0]   = 8'hFF;
    repeat (3) step();
    #1;
    check("cfg_hold_data", data_in, 8'h5A);
    check("cfg_hold_len", data_length, 1'b1);
    check("cfg_hold_stop", stop_bits, 1'b1);
    check("cfg_hold_pt", parity_type, 2'b10);
    check("cfg_hold_par", parity_in, 1'b0);
    tx_active = 1'b0;
    step();
    grant_one(2, 8'h3C, 1'b0, 1'b0, 2'b01);
    check("cfg_new_len", data_length, 1'b0);
    check("cfg_new_pt", parity_type, 2'b01);
    check("cfg_new_par", parity_in, 1'b1);
    serve(1, 2);

    // reset while ACTIVE, then pending requests resume from index 0
    grant_one(1, 8'h99, 1'b1, 1'b0, 2'b01);
    step();
    tx_active = 1'b1;
    step();
    req_data[7:0] = 8'hA5;
    req = 4'b1111;
    arst_n = 1'b0;
    tx_active = 1'b0;
    #1;
    check("ar_send", send, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_data", data_in, 8'h00);
    check("ar_len", data_length, 1'b1);
    check("ar_pt", parity_type, 2'b00);
    check("ar_par", parity_in, 1'b0);
    check("ar_gnt", gnt, 4'b0000);
    step();
    arst_n = 1'b1;
    #1;
    check("ar_first_gnt", gnt, 4'b0001);
    step();
    req = 4'b0000;
    #1;
    check("ar_first_data", data_in, 8'hA5);
    check("ar_first_par", parity_in, 1'b1);
    serve(1, 2);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART frame transmitter among `N_REQ` byte requesters. It arbitrates pending requests and latches the winning byte together with the frame configuration. It computes the parity bit, drives the transmitter's `send` and waits for the frame to finish before granting the next requester. It sits between client logic and the parallel-in/serial-out transmitter, in the same `baud_clk` domain.

## Interface

Parameters:

- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 15: cycles allowed in SEND for the transmitter to assert `tx_active`.

Ports (clock and reset first):

- `baud_clk` input 1: single clock; all logic on its rising edge.
- `arst_n` input 1: reset, asynchronous, active-low.
- `req` input N_REQ: level request per requester; held until granted.
- `req_data` input 8*N_REQ: byte of requester i at bits [8i+7:8i].
- `cfg_data_length` input 1: 1 = 8 data bits, 0 = 7 data bits.
- `cfg_stop_bits` input 1: 1 = two stop bits.
- `cfg_parity_type` input 2: 00 none, 01 odd, 10 even, 11 none (parity only reported on `parity_in`).
- `gnt` output N_REQ: one-hot, one-cycle pulse when requester i's byte is accepted.
- `busy` output 1: high in any state other than IDLE.
- `timeout_err` output 1: one-cycle pulse on SEND timeout.
- `send` output 1: transmitter start request.
- `data_in` output 8: latched byte to transmitter.
- `data_length` output 1: latched copy of `cfg_data_length`.
- `stop_bits` output 1: latched copy of `cfg_stop_bits`.
- `parity_type` output 2: latched copy of `cfg_parity_type`.
- `parity_in` output 1: computed parity bit.
- `tx_active` input 1: transmitter framing in progress.
- `tx_done` input 1: transmitter idle or in stop bit.

## Operation

- FSM states:
  - IDLE: if `req` != 0, select the winner, latch byte and config, pulse `gnt[w]`, go to SEND.
  - SEND: `send`=1. If `tx_active`=1, go to ACTIVE. If the timeout counter reaches `TIMEOUT`, pulse `timeout_err` and go to IDLE.
  - ACTIVE: `send`=0. On `tx_active`=0 (stop bit reached), go to IDLE.
- Round-robin arbitration:
  - Pointer `last` holds the index of the most recent grant; reset value is N_REQ-1.
  - The search starts at `last`+1 mod N_REQ, and the first set `req` bit wins.
  - `last` updates only on grant. A timed-out frame still counts as granted.
- Parity is computed from the latched byte over bits [6:0], plus bit [7] only when latched `data_length`=1.
  - Even type (10): `parity_in` = XOR of the counted bits.
  - Odd type (01): `parity_in` = XNOR of the counted bits.
  - Types 00 and 11: `parity_in` = XOR of the counted bits.
- Latched outputs (`data_in`, `data_length`, `stop_bits`, `parity_type`, `parity_in`) change only at grant. `cfg_*` changes mid-frame have no effect until the next grant.
- Request and grant handshake:
  - A requester drops `req` the cycle after seeing `gnt`.
  - A `req` held past `gnt` is treated as a new request.
  - A requester's request is not re-served while other requesters are pending, because of the round-robin order.

## Timing

- Reset (async assert) values: state IDLE, `gnt`=0, `busy`=0, `timeout_err`=0, `send`=0, `data_in`=8'h00, `data_length`=1, `stop_bits`=0, `parity_type`=00, `parity_in`=0, `last`=N_REQ-1, timeout counter 0.
- Reset mid-frame drops `send` immediately; the transmitter shares `arst_n`.
- Latency for `req` in IDLE:
  - `gnt` pulses in that same IDLE cycle (combinational from registered state and `req`, registered outputs update at the edge).
  - `send` is high from the next cycle.
- `send` stays high until the first edge where `tx_active`=1 is sampled. This tolerates the transmitter still being in its second stop bit and accepting `send` only in its own idle state.
- Timeout counter:
  - Clears on entry to SEND and counts each SEND cycle.
  - `timeout_err` pulses on the cycle the count equals `TIMEOUT`, and the FSM goes to IDLE on that edge.
- Minimum gap is 1 IDLE cycle between `tx_active` falling and the next `send`. That IDLE cycle is also the grant cycle.
- Simultaneous events:
  - Multiple `req` in the same cycle: only one grant, chosen by round-robin.
  - `req` arriving while `busy`: waits, no grant.
  - `tx_active`=1 and the timeout in the same SEND cycle: `tx_active` wins (go to ACTIVE, no error).

## Test plan

- Reset, then `req`=4'b0001 with byte 0x41, 8-bit, even parity -> `gnt`=0001 for one cycle, `data_in`=0x41, `parity_in`=0, `send` high until `tx_active`, `busy` low after the frame.
- `req`=4'b1111 held continuously for 8 frames -> grant order 0,1,2,3,0,1,2,3 starting from reset pointer 3. No back-to-back grant to the same index.
- Byte 0xC3, 7-bit, odd (01) -> counted bits 0x43 have 3 ones, `parity_in`=0. The same byte with 8-bit even -> `parity_in`=0. 8-bit odd -> `parity_in`=1.
- Model `tx_active` held low for 20 cycles -> `timeout_err` pulses exactly at the 15th SEND cycle, FSM returns to IDLE, and the next request is granted at the following arbitration point.
- Change `cfg_parity_type` and `cfg_data_length` while ACTIVE -> latched outputs stay constant until the next `gnt`.
- Deassert `arst_n` while ACTIVE -> all outputs take their reset values in the same cycle. After release, the pending `req` is granted starting from index 0.
